// File: rtl/bitty_core_gen2.sv
// Small accumulator-style core: eight registers, one ALU, four-state execute sequence.
// Latency: done is high in the 4th cycle after a run is accepted; one instruction per 4 cycles.
// Backpressure: none; run is sampled only in IDLE and DONE and ignored while an instruction is in flight.
module bitty_core_gen2 #(
  parameter int DATA_W = 16,
  parameter int NREGS  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  input  logic [15:0]       instruction,
  output logic              done,
  output logic              busy,
  output logic [DATA_W-1:0] result,
  output logic              flag_zero,
  output logic              flag_carry,
  output logic              illegal,
  input  logic [2:0]        dbg_sel,
  output logic [DATA_W-1:0] dbg_data
);

  localparam int SH_W = $clog2(DATA_W);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_LOAD = 3'd1;
  localparam logic [2:0] ST_EXEC = 3'd2;
  localparam logic [2:0] ST_WB   = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_CMP = 3'b111;

  logic [2:0]        state;
  logic [15:0]       ir;
  logic [DATA_W-1:0] s_reg;
  logic [DATA_W-1:0] c_reg;
  logic              z_reg;
  logic              cy_reg;
  logic [DATA_W-1:0] regs [0:NREGS-1];

  // Instruction field decode from the captured instruction register.
  logic [2:0]        rx;
  logic [2:0]        ry;
  logic [7:0]        imm8;
  logic [2:0]        alu_sel;
  logic [1:0]        fmt;
  logic              fmt_reserved;
  logic [DATA_W-1:0] b_val;
  logic [SH_W-1:0]   shamt;

  assign rx           = ir[15:13];
  assign ry           = ir[12:10];
  assign imm8         = ir[12:5];
  assign alu_sel      = ir[4:2];
  assign fmt          = ir[1:0];
  assign fmt_reserved = fmt[1];

  // Register operand for fmt 00, zero-extended immediate otherwise; read in EXEC so Rx==Ry sees the old value.
  assign b_val = (fmt == 2'b01) ? DATA_W'(imm8) : regs[ry];
  assign shamt = b_val[SH_W-1:0];

  logic [DATA_W:0]   sum_ext;
  logic [DATA_W:0]   diff_ext;
  logic [DATA_W-1:0] alu_res;
  logic              alu_carry;

  assign sum_ext  = {1'b0, s_reg} + {1'b0, b_val};
  // The extra top bit of the widened subtraction is the borrow.
  assign diff_ext = {1'b0, s_reg} - {1'b0, b_val};

  // ALU: pick the result and carry for the selected operation.
  always_comb begin
    alu_res   = '0;
    alu_carry = 1'b0;
    case (alu_sel)
      OP_ADD: begin
        alu_res   = sum_ext[DATA_W-1:0];
        alu_carry = sum_ext[DATA_W];
      end
      OP_SUB: begin
        alu_res   = diff_ext[DATA_W-1:0];
        alu_carry = diff_ext[DATA_W];
      end
      OP_AND:  alu_res = s_reg & b_val;
      OP_OR:   alu_res = s_reg | b_val;
      OP_XOR:  alu_res = s_reg ^ b_val;
      OP_SHL:  alu_res = s_reg << shamt;
      OP_SHR:  alu_res = s_reg >> shamt;
      OP_CMP: begin
        if (s_reg == b_val)
          alu_res = '0;
        else if (s_reg > b_val)
          alu_res = DATA_W'(1);
        else
          alu_res = DATA_W'(2);
      end
      default: alu_res = '0;
    endcase
  end

  // Sequencer and architectural state; reset clears everything and aborts any in-flight write.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= ST_IDLE;
      ir     <= '0;
      s_reg  <= '0;
      c_reg  <= '0;
      z_reg  <= 1'b0;
      cy_reg <= 1'b0;
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else begin
      case (state)
        ST_IDLE: begin
          if (run) begin
            ir    <= instruction;
            state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          s_reg <= regs[rx];
          state <= ST_EXEC;
        end
        ST_EXEC: begin
          // Reserved formats leave C and the flags untouched.
          if (!fmt_reserved) begin
            c_reg  <= alu_res;
            z_reg  <= (alu_res == '0);
            cy_reg <= alu_carry;
          end
          state <= ST_WB;
        end
        ST_WB: begin
          if (!fmt_reserved) begin
            regs[rx] <= c_reg;
          end
          state <= ST_DONE;
        end
        ST_DONE: begin
          // Back-to-back issue straight from DONE skips the IDLE cycle.
          if (run) begin
            ir    <= instruction;
            state <= ST_LOAD;
          end else begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign done       = (state == ST_DONE);
  assign busy       = (state != ST_IDLE);
  assign illegal    = (state == ST_DONE) && fmt_reserved;
  assign result     = c_reg;
  assign flag_zero  = z_reg;
  assign flag_carry = cy_reg;
  assign dbg_data   = regs[dbg_sel];

endmodule

// File: tb/tb_bitty_core_gen2.sv
module tb_bitty_core_gen2;

  logic        clk;
  logic        reset;
  logic        run;
  logic [15:0] instruction;
  logic        done;
  logic        busy;
  logic [15:0] result;
  logic        flag_zero;
  logic        flag_carry;
  logic        illegal;
  logic [2:0]  dbg_sel;
  logic [15:0] dbg_data;

  bitty_core_gen2 #(.DATA_W(16), .NREGS(8)) dut (
    .clk(clk), .reset(reset), .run(run), .instruction(instruction),
    .done(done), .busy(busy), .result(result), .flag_zero(flag_zero),
    .flag_carry(flag_carry), .illegal(illegal), .dbg_sel(dbg_sel), .dbg_data(dbg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  int unsigned m_r [8];
  int unsigned m_c;
  bit          m_z, m_cy;
  int          age;          // cycles since the in-flight instruction was accepted, 0 when idle
  int unsigned p_res;
  bit          p_z, p_cy, p_ill;
  int          p_rx;
  bit          started = 1'b0;

  task automatic alu_model(input int unsigned s, input int unsigned b, input int op,
                           output int unsigned r, output bit cy);
    longint unsigned wide;
    cy = 1'b0;
    case (op)
      0: begin wide = longint'(s) + longint'(b); cy = (wide > 65535); r = int'(wide % 65536); end
      1: begin cy = (s < b); r = (s + 65536 - b) % 65536; end
      2: r = s & b;
      3: r = s | b;
      4: r = s ^ b;
      5: r = (s << (b % 16)) % 65536;
      6: r = s >> (b % 16);
      default: r = (s == b) ? 0 : ((s > b) ? 1 : 2);
    endcase
  endtask

  task automatic model_accept(input logic [15:0] ins);
    int unsigned s, b;
    int fmt;
    fmt   = int'(ins[1:0]);
    p_rx  = int'(ins[15:13]);
    s     = m_r[p_rx];
    b     = (fmt == 0) ? m_r[int'(ins[12:10])] : int'(ins[12:5]);
    p_ill = (fmt >= 2);
    alu_model(s, b, int'(ins[4:2]), p_res, p_cy);
    p_z   = (p_res == 0);
    age   = 1;
  endtask

  always @(posedge clk) begin
    cyc++;
    started = 1'b1;
    if (!reset) begin
      for (int i = 0; i < 8; i++) m_r[i] = 0;
      m_c = 0; m_z = 0; m_cy = 0; age = 0; p_ill = 0;
    end else begin
      case (age)
        0: if (run) model_accept(instruction);
        1: age = 2;
        2: begin
          if (!p_ill) begin m_c = p_res; m_z = p_z; m_cy = p_cy; end
          age = 3;
        end
        3: begin
          if (!p_ill) m_r[p_rx] = m_c;
          age = 4;
        end
        default: if (run) model_accept(instruction); else age = 0;
      endcase
    end
  end

  // Per-cycle compare of every DUT output against the model.
  always @(negedge clk) begin
    if (started) begin
      chk("busy",     busy,       (age != 0));
      chk("done",     done,       (age == 4));
      chk("illegal",  illegal,    (age == 4) && p_ill);
      chk("result",   result,     m_c);
      chk("zero",     flag_zero,  m_z);
      chk("carry",    flag_carry, m_cy);
      chk("dbg_data", dbg_data,   m_r[dbg_sel]);
    end
  end

  // Debug select sweeps all registers continuously.
  initial begin
    dbg_sel = 3'd0;
    forever begin
      @(posedge clk);
      #1 dbg_sel = dbg_sel + 3'd1;
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic do_reset();
    @(posedge clk); #1 reset = 1'b0; run = 1'b0;
    @(posedge clk); #1 reset = 1'b1;
  endtask

  task automatic wait_done(output int k);
    k = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (done) begin k = i; break; end
    end
    if (k == 0) chk("done_timeout", 0, 1);
  endtask

  task automatic issue(input logic [15:0] ins, output int k);
    @(posedge clk); #1 run = 1'b1; instruction = ins;
    @(posedge clk); #1 run = 1'b0;
    wait_done(k);
  endtask

  initial begin
    int k, d1, d2;
    reset = 1'b0; run = 1'b0; instruction = 16'h0000;
    @(posedge clk); @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_result", result, 0);

    // R1 = R1 + 5: latency 4
    issue(16'h20A1, k);
    chk("latency", k, 4);
    chk("lit_add_result", result, 16'h0005);
    chk("lit_add_zero", flag_zero, 0);
    chk("lit_add_carry", flag_carry, 0);
    chk("model_r1", m_r[1], 16'h0005);

    // R2 = R2 - R1 -> borrow
    issue(16'h4404, k);
    chk("lit_sub_result", result, 16'hFFFB);
    chk("lit_sub_carry", flag_carry, 1);
    chk("lit_sub_zero", flag_zero, 0);
    chk("model_r2", m_r[2], 16'hFFFB);

    // Back-to-back from DONE with run held high
    do_reset();
    @(posedge clk); #1 run = 1'b1; instruction = 16'h20A1;
    wait_done(k);
    d1 = cyc;
    @(posedge clk); #1 run = 1'b0;
    chk("b2b_busy_after_done", busy, 1);
    wait_done(k);
    d2 = cyc;
    chk("b2b_spacing", d2 - d1, 4);
    chk("lit_b2b_result", result, 16'h000A);
    chk("model_r1_b2b", m_r[1], 16'h000A);

    // Reserved formats: illegal with done, no state change
    issue(16'h20A3, k);
    chk("lit_ill_flag", illegal, 1);
    chk("lit_ill_result", result, 16'h000A);
    @(negedge clk);
    chk("lit_ill_one_cycle", illegal, 0);
    issue(16'h20A2, k);
    chk("lit_ill10_flag", illegal, 1);
    chk("model_r1_ill", m_r[1], 16'h000A);

    // Reset during EXEC aborts the write
    @(posedge clk); #1 run = 1'b1; instruction = 16'h20A1;
    @(posedge clk); #1 run = 1'b0;
    @(posedge clk); #1 reset = 1'b0;
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    chk("lit_abort_busy", busy, 0);
    chk("lit_abort_result", result, 0);
    chk("model_r1_abort", m_r[1], 0);

    // Compare against immediates
    issue(16'h7FE1, k);
    chk("lit_load_r3", result, 16'h00FF);
    issue(16'h621D, k);
    chk("lit_cmp_gt", result, 16'h0001);
    do_reset();
    issue(16'h7FE1, k);
    issue(16'h7FFD, k);
    chk("lit_cmp_eq", result, 16'h0000);
    chk("lit_cmp_eq_zero", flag_zero, 1);

    // Shifts, Rx==Ry add with carry, logic ops
    do_reset();
    issue(16'h7FE1, k);                  // R3 = 0x00FF
    issue(16'h6115, k);                  // R3 <<= 8
    chk("lit_shl", result, 16'hFF00);
    issue(16'h6C00, k);                  // R3 = R3 + R3
    chk("lit_add_self", result, 16'hFE00);
    chk("lit_add_self_carry", flag_carry, 1);
    issue(16'h6139, k);                  // R3 >>= 9
    chk("lit_shr", result, 16'h007F);
    issue(16'h6FF1, k);                  // R3 ^= 0x7F
    chk("lit_xor_zero", flag_zero, 1);
    issue(16'h678D, k);                  // R3 |= 0x3C
    chk("lit_or", result, 16'h003C);
    issue(16'h61E9, k);                  // R3 &= 0x0F
    chk("lit_and", result, 16'h000C);
    chk("model_r3", m_r[3], 16'h000C);

    repeat (3) @(posedge clk);
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
